// File: rtl/ctrl_pkg.sv
// Shared types and constants for the five-stage pipeline controller:
// FSM state encoding and MIPS exception codes as presented by the MEM stage.
package ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    EXC_WAIT = 2'd1,
    REDIRECT = 2'd2
  } pipe_state_t;

  localparam logic [31:0] EXC_INT     = 32'h0000_0001;
  localparam logic [31:0] EXC_SYSCALL = 32'h0000_0008;
  localparam logic [31:0] EXC_OV      = 32'h0000_000C;
  localparam logic [31:0] EXC_ERET    = 32'h0000_000E;

endpackage

// File: rtl/exc_target.sv
// Maps the MEM-stage exception code to the PC the front end must restart from:
// eret returns to EPC, every other exception enters the general vector.
module exc_target
  import ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
  input  logic [31:0] except_type,
  input  logic [31:0] cp0_epc,
  output logic [31:0] target
);

  assign target = (except_type == EXC_ERET) ? cp0_epc : EXC_VECTOR;

endmodule

// File: rtl/pipe_ctrl.sv
// Central stall/flush/redirect controller for the five-stage MIPS pipeline.
// Optional PIPE_CTRL_PERF_EN adds stall_cycles and flush_events counters.
module pipe_ctrl
  import ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_stall_req,
  input  logic        id_stall_req,
  input  logic        ex_stall_req,
  input  logic        mem_stall_req,
  input  logic [31:0] mem_except_type,
  input  logic [31:0] cp0_epc,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        id_ex_en,
  output logic        ex_mem_en,
  output logic        mem_wb_en,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        ex_mem_flush,
  output logic        mem_wb_flush,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic [1:0]  ctrl_state
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events
`endif
);

  // Both vectors must be word aligned for the fetch unit to use them.
  if ((RESET_VECTOR[1:0] | EXC_VECTOR[1:0]) != 2'b00) begin : g_vec_misaligned
    $error("pipe_ctrl: RESET_VECTOR and EXC_VECTOR must be word aligned");
  end

  pipe_state_t state, next_state;
  logic [31:0] target;
  logic        exc_pending;

  assign exc_pending = (mem_except_type != 32'd0);
  assign ctrl_state  = state;

  exc_target #(
    .EXC_VECTOR(EXC_VECTOR)
  ) u_exc_target (
    .except_type(mem_except_type),
    .cp0_epc    (cp0_epc),
    .target     (target)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      redirect_pc <= 32'd0;
    end else begin
      state <= next_state;
      // Target is captured only when the exception is first seen in RUN.
      if (state == RUN && exc_pending)
        redirect_pc <= target;
    end
  end

  always_comb begin
    next_state   = state;
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    mem_wb_flush = 1'b0;
    redirect     = 1'b0;
    unique case (state)
      RUN: begin
        if (mem_stall_req) begin
          {pc_en, if_id_en, id_ex_en, ex_mem_en} = 4'b0000;
          mem_wb_flush = 1'b1;
          if (exc_pending) next_state = EXC_WAIT;
        end else if (exc_pending) begin
          {if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush} = 4'b1111;
          next_state = REDIRECT;
        end else if (ex_stall_req) begin
          {pc_en, if_id_en, id_ex_en} = 3'b000;
          ex_mem_flush = 1'b1;
        end else if (id_stall_req) begin
          {pc_en, if_id_en} = 2'b00;
          id_ex_flush = 1'b1;
        end else if (if_stall_req) begin
          pc_en       = 1'b0;
          if_id_flush = 1'b1;
        end
      end
      EXC_WAIT: begin
        if (mem_stall_req) begin
          {pc_en, if_id_en, id_ex_en, ex_mem_en} = 4'b0000;
          mem_wb_flush = 1'b1;
        end else begin
          {if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush} = 4'b1111;
          next_state = REDIRECT;
        end
      end
      REDIRECT: begin
        // Hold the redirect until any in-flight fetch has drained.
        redirect = 1'b1;
        {if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush} = 4'b1111;
        if (!if_stall_req) next_state = RUN;
      end
      default: next_state = RUN;
    endcase
  end

`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= 32'd0;
      flush_events <= 32'd0;
    end else begin
      if (state == RUN && !pc_en)
        stall_cycles <= stall_cycles + 32'd1;
      if (state != REDIRECT && next_state == REDIRECT)
        flush_events <= flush_events + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: table of RUN-state stall vectors plus
// hand-written exception, deferral, redirect-drain and async-reset sequences.
module tb_pipe_ctrl;
  import ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_stall_req, id_stall_req, ex_stall_req, mem_stall_req;
  logic [31:0] mem_except_type, cp0_epc;
  logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic        if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [1:0]  ctrl_state;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cycles, flush_events;
  logic [31:0] fe_before;
`endif

  pipe_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .if_stall_req   (if_stall_req),
    .id_stall_req   (id_stall_req),
    .ex_stall_req   (ex_stall_req),
    .mem_stall_req  (mem_stall_req),
    .mem_except_type(mem_except_type),
    .cp0_epc        (cp0_epc),
    .pc_en          (pc_en),
    .if_id_en       (if_id_en),
    .id_ex_en       (id_ex_en),
    .ex_mem_en      (ex_mem_en),
    .mem_wb_en      (mem_wb_en),
    .if_id_flush    (if_id_flush),
    .id_ex_flush    (id_ex_flush),
    .ex_mem_flush   (ex_mem_flush),
    .mem_wb_flush   (mem_wb_flush),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .ctrl_state     (ctrl_state)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .stall_cycles   (stall_cycles),
    .flush_events   (flush_events)
`endif
  );

  always #5 clk = ~clk;

  // Enables {pc, if_id, id_ex, ex_mem, mem_wb}; flushes {if_id, id_ex, ex_mem, mem_wb}
  localparam logic [4:0] EN_ALL = 5'b11111, EN_IF = 5'b01111, EN_ID = 5'b00111,
                         EN_EX  = 5'b00011, EN_MEM = 5'b00001;
  localparam logic [3:0] FL_NONE = 4'b0000, FL_IF = 4'b1000, FL_ID = 4'b0100,
                         FL_EX   = 4'b0010, FL_MEM = 4'b0001, FL_ALL = 4'b1111;
  // Stall request codes {mem, ex, id, if}
  localparam logic [3:0] S_NONE = 4'b0000, S_IF = 4'b0001, S_ID = 4'b0010,
                         S_EX   = 4'b0100, S_MEM = 4'b1000;
  localparam logic [31:0] EXC_VEC = 32'hBFC0_0380;
  localparam logic [31:0] EPC_A   = 32'hBFC0_0104;

  typedef struct packed {
    logic [4:0]  en;
    logic [3:0]  fl;
    logic        redir;
    logic        chk_rpc;
    logic [31:0] rpc;
    logic [1:0]  st;
  } exp_t;

  typedef struct packed {
    logic [3:0] stl;
    logic [4:0] en;
    logic [3:0] fl;
  } vec_t;

  exp_t  exp_q[$];
  string nm_q[$];
  int    n_chk = 0;
  int    n_fail = 0;
  vec_t  tbl[12];

  function automatic exp_t mk(input logic [4:0] en, input logic [3:0] fl, input logic redir,
                              input logic chk, input logic [31:0] rpc, input logic [1:0] st);
    exp_t e;
    e.en = en; e.fl = fl; e.redir = redir; e.chk_rpc = chk; e.rpc = rpc; e.st = st;
    return e;
  endfunction

  task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  task automatic check_front();
    exp_t  e;
    string nm;
    if (exp_q.size() == 0) begin
      n_chk++; n_fail++;
      $display("FAIL scoreboard_empty: got 0 entries, expected 1");
      return;
    end
    e  = exp_q.pop_front();
    nm = nm_q.pop_front();
    cmp({nm, "_en"}, {27'd0, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}, {27'd0, e.en});
    cmp({nm, "_flush"}, {28'd0, if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush}, {28'd0, e.fl});
    cmp({nm, "_redirect"}, {31'd0, redirect}, {31'd0, e.redir});
    cmp({nm, "_state"}, {30'd0, ctrl_state}, {30'd0, e.st});
    if (e.chk_rpc) cmp({nm, "_redirect_pc"}, redirect_pc, e.rpc);
  endtask

  // Drive one cycle's inputs just after the edge, check at the falling edge.
  task automatic cyc(input logic [3:0] stl, input logic [31:0] et, input logic [31:0] epc,
                     input exp_t e, input string nm);
    {mem_stall_req, ex_stall_req, id_stall_req, if_stall_req} = stl;
    mem_except_type = et;
    cp0_epc         = epc;
    exp_q.push_back(e);
    nm_q.push_back(nm);
    @(negedge clk);
    check_front();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0]  = '{stl: S_NONE,               en: EN_ALL, fl: FL_NONE};
    tbl[1]  = '{stl: S_IF,                 en: EN_IF,  fl: FL_IF};
    tbl[2]  = '{stl: S_ID,                 en: EN_ID,  fl: FL_ID};
    tbl[3]  = '{stl: S_NONE,               en: EN_ALL, fl: FL_NONE};
    tbl[4]  = '{stl: S_EX,                 en: EN_EX,  fl: FL_EX};
    tbl[5]  = '{stl: S_MEM,                en: EN_MEM, fl: FL_MEM};
    tbl[6]  = '{stl: S_ID | S_IF,          en: EN_ID,  fl: FL_ID};
    tbl[7]  = '{stl: S_EX | S_IF,          en: EN_EX,  fl: FL_EX};
    tbl[8]  = '{stl: S_MEM | S_EX,         en: EN_MEM, fl: FL_MEM};
    tbl[9]  = '{stl: S_MEM | S_ID | S_IF,  en: EN_MEM, fl: FL_MEM};
    tbl[10] = '{stl: 4'b1111,              en: EN_MEM, fl: FL_MEM};
    tbl[11] = '{stl: S_NONE,               en: EN_ALL, fl: FL_NONE};

    rst = 1'b1;
    {mem_stall_req, ex_stall_req, id_stall_req, if_stall_req} = S_NONE;
    mem_except_type = 32'd0;
    cp0_epc = 32'd0;
    cyc(S_NONE, 32'd0, 32'd0, mk(EN_ALL, FL_NONE, 1'b0, 1'b1, 32'd0, RUN), "reset");
    rst = 1'b0;

    for (int i = 0; i < 12; i++)
      cyc(tbl[i].stl, 32'd0, 32'd0, mk(tbl[i].en, tbl[i].fl, 1'b0, 1'b0, 32'd0, RUN),
          $sformatf("tbl%0d", i));

    // Single-cycle load-use stall, then free-running
    cyc(S_ID,   32'd0, 32'd0, mk(EN_ID,  FL_ID,   1'b0, 1'b0, 32'd0, RUN), "id_once");
    cyc(S_NONE, 32'd0, 32'd0, mk(EN_ALL, FL_NONE, 1'b0, 1'b0, 32'd0, RUN), "id_after");

    // EX busy 3 cycles overlapping a load-use hazard
    for (int i = 0; i < 3; i++)
      cyc(S_EX | S_ID, 32'd0, 32'd0, mk(EN_EX, FL_EX, 1'b0, 1'b0, 32'd0, RUN), "ex_id");
    cyc(S_NONE, 32'd0, 32'd0, mk(EN_ALL, FL_NONE, 1'b0, 1'b0, 32'd0, RUN), "ex_after");

    // Overflow exception with no stall: flush, one redirect cycle, back to RUN
    cyc(S_NONE, EXC_OV, 32'h1234_5678, mk(EN_ALL, FL_ALL, 1'b0, 1'b0, 32'd0, RUN), "ov_flush");
    cyc(S_NONE, 32'd0, 32'd0, mk(EN_ALL, FL_ALL, 1'b1, 1'b1, EXC_VEC, REDIRECT), "ov_redir");
    cyc(S_NONE, 32'd0, 32'd0, mk(EN_ALL, FL_NONE, 1'b0, 1'b0, 32'd0, RUN), "ov_run");

    // eret deferred behind a 4-cycle MEM stall; later codes/EPC must not re-latch
    cyc(S_MEM, EXC_ERET, EPC_A, mk(EN_MEM, FL_MEM, 1'b0, 1'b0, 32'd0, RUN), "eret_defer");
    for (int i = 0; i < 3; i++)
      cyc(S_MEM | S_EX | S_ID, EXC_SYSCALL, 32'h1234_5678,
          mk(EN_MEM, FL_MEM, 1'b0, 1'b1, EPC_A, EXC_WAIT), "eret_wait");
    cyc(S_NONE, 32'd0, 32'd0, mk(EN_ALL, FL_ALL, 1'b0, 1'b0, 32'd0, EXC_WAIT), "eret_flush");
    cyc(S_NONE, 32'd0, 32'd0, mk(EN_ALL, FL_ALL, 1'b1, 1'b1, EPC_A, REDIRECT), "eret_redir");
    cyc(S_NONE, 32'd0, 32'd0, mk(EN_ALL, FL_NONE, 1'b0, 1'b0, 32'd0, RUN), "eret_run");

    // Redirect held while the fetch unit drains
`ifdef PIPE_CTRL_PERF_EN
    fe_before = flush_events;
`endif
    cyc(S_NONE, EXC_INT, 32'd0, mk(EN_ALL, FL_ALL, 1'b0, 1'b0, 32'd0, RUN), "drain_flush");
    cyc(S_IF,   32'd0, 32'd0, mk(EN_ALL, FL_ALL, 1'b1, 1'b1, EXC_VEC, REDIRECT), "drain_r1");
    cyc(S_IF,   32'd0, 32'd0, mk(EN_ALL, FL_ALL, 1'b1, 1'b1, EXC_VEC, REDIRECT), "drain_r2");
    cyc(S_NONE, 32'd0, 32'd0, mk(EN_ALL, FL_ALL, 1'b1, 1'b1, EXC_VEC, REDIRECT), "drain_r3");
    cyc(S_NONE, 32'd0, 32'd0, mk(EN_ALL, FL_NONE, 1'b0, 1'b0, 32'd0, RUN), "drain_run");
`ifdef PIPE_CTRL_PERF_EN
    cmp("flush_events", flush_events, fe_before + 32'd1);
`endif

    // Asynchronous reset while waiting in EXC_WAIT discards the target
    cyc(S_MEM, EXC_SYSCALL, 32'd0, mk(EN_MEM, FL_MEM, 1'b0, 1'b0, 32'd0, RUN), "rst_defer");
    cmp("rst_pre_state", {30'd0, ctrl_state}, {30'd0, EXC_WAIT});
    rst = 1'b1;
    #1;
    cmp("rst_async_state", {30'd0, ctrl_state}, {30'd0, RUN});
    cmp("rst_async_redirect", {31'd0, redirect}, 32'd0);
    cmp("rst_async_redirect_pc", redirect_pc, 32'd0);
    {mem_stall_req, ex_stall_req, id_stall_req, if_stall_req} = S_NONE;
    mem_except_type = 32'd0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(S_NONE, 32'd0, 32'd0, mk(EN_ALL, FL_NONE, 1'b0, 1'b1, 32'd0, RUN), "rst_after1");
    cyc(S_NONE, 32'd0, 32'd0, mk(EN_ALL, FL_NONE, 1'b0, 1'b1, 32'd0, RUN), "rst_after2");

    if (exp_q.size() != 0) begin
      n_chk++; n_fail++;
      $display("FAIL scoreboard_leftover: got %0d entries, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
